// File: rtl/box_mean_kxk.sv
// K x K box-mean filter over a raster pixel stream, using line buffers and running column/row sums.
// Define BOX_MEAN_ROUND_EN for round-to-nearest; the default build truncates.
module box_mean_kxk #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int KSIZE        = 7,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              out_eof
);
    localparam int R     = (KSIZE - 1) / 2;
    localparam int AREA  = KSIZE * KSIZE;
    localparam int NLB   = KSIZE - 1;
    localparam int CS_W  = DATA_W + $clog2(KSIZE);
    localparam int SUM_W = DATA_W + $clog2(AREA);
    localparam int CW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] FIRST_OUT = 16'(KSIZE - 1);

    function automatic logic [DATA_W-1:0] mean_f(input logic [SUM_W-1:0] s);
        logic [SUM_W:0] t;
`ifdef BOX_MEAN_ROUND_EN
        t = {1'b0, s} + (SUM_W+1)'(AREA / 2);
`else
        t = {1'b0, s};
`endif
        return DATA_W'(t / (SUM_W+1)'(AREA));
    endfunction

    logic              sof_hit;
    logic [15:0]       col_eff, row_eff;
    logic [CW-1:0]     col_idx;
    logic [15:0]       col_q, col_d, row_q, row_d;
    logic [DATA_W-1:0] lb_q    [NLB][IMAGE_WIDTH];
    logic [DATA_W-1:0] lb_wr_d [NLB];

    logic [CS_W-1:0]   col_sum_p0_q, col_sum_p0_d;
    logic [15:0]       col_p0_q, col_p0_d, row_p0_q, row_p0_d;
    logic              acc_p0_q, acc_p0_d, vld_p0_q, vld_p0_d, eof_p0_q, eof_p0_d;

    logic [CS_W-1:0]   hist_q [KSIZE];
    logic [CS_W-1:0]   hist_d [KSIZE];
    logic [SUM_W-1:0]  win_sum_p1_q, win_sum_p1_d;
    logic [15:0]       col_p1_q, col_p1_d, row_p1_q, row_p1_d;
    logic              vld_p1_q, vld_p1_d, eof_p1_q, eof_p1_d;

    logic              out_valid_q, out_valid_d, out_eof_q, out_eof_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [15:0]       out_row_q, out_row_d, out_col_q, out_col_d;

    assign col_idx = col_eff[CW-1:0];

    always_comb begin
        // stage p0: position tracking, line-buffer read and column sum
        sof_hit = in_valid && in_sof;
        col_eff = sof_hit ? 16'd0 : col_q;
        row_eff = sof_hit ? 16'd0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (col_eff == LAST_COL) begin
                col_d = 16'd0;
                row_d = (row_eff == LAST_ROW) ? 16'd0 : row_eff + 16'd1;
            end else begin
                col_d = col_eff + 16'd1;
                row_d = row_eff;
            end
        end
        col_sum_p0_d = CS_W'(in_data);
        for (int i = 0; i < NLB; i++)
            col_sum_p0_d = col_sum_p0_d + CS_W'(lb_q[i][col_idx]);
        lb_wr_d[0] = in_data;
        for (int i = 1; i < NLB; i++)
            lb_wr_d[i] = lb_q[i-1][col_idx];
        acc_p0_d = in_valid;
        vld_p0_d = in_valid && (row_eff >= FIRST_OUT) && (col_eff >= FIRST_OUT);
        eof_p0_d = in_valid && (row_eff == LAST_ROW) && (col_eff == LAST_COL);
        col_p0_d = col_eff;
        row_p0_d = row_eff;

        // stage p1: running window sum over the last K column sums of this line
        hist_d       = hist_q;
        win_sum_p1_d = win_sum_p1_q;
        if (acc_p0_q) begin
            hist_d[0] = col_sum_p0_q;
            for (int i = 1; i < KSIZE; i++)
                hist_d[i] = hist_q[i-1];
            if (col_p0_q == 16'd0)
                win_sum_p1_d = SUM_W'(col_sum_p0_q);
            else
                win_sum_p1_d = win_sum_p1_q + SUM_W'(col_sum_p0_q)
                             - ((col_p0_q >= 16'(KSIZE)) ? SUM_W'(hist_q[KSIZE-1]) : '0);
        end
        vld_p1_d = vld_p0_q;
        eof_p1_d = eof_p0_q;
        col_p1_d = col_p0_q;
        row_p1_d = row_p0_q;

        // stage p2: divide and present, holding the last result between strobes
        out_valid_d = vld_p1_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_eof_d   = out_eof_q;
        if (vld_p1_q) begin
            out_data_d = mean_f(win_sum_p1_q);
            out_row_d  = row_p1_q - 16'(R);
            out_col_d  = col_p1_q - 16'(R);
            out_eof_d  = eof_p1_q;
        end
    end

    // Line buffers are never cleared: rows below K-1 are gated off at the output.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int i = 0; i < NLB; i++)
                lb_q[i][col_idx] <= lb_wr_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            col_sum_p0_q <= '0;
            col_p0_q     <= '0;
            row_p0_q     <= '0;
            acc_p0_q     <= 1'b0;
            vld_p0_q     <= 1'b0;
            eof_p0_q     <= 1'b0;
            for (int i = 0; i < KSIZE; i++)
                hist_q[i] <= '0;
            win_sum_p1_q <= '0;
            col_p1_q     <= '0;
            row_p1_q     <= '0;
            vld_p1_q     <= 1'b0;
            eof_p1_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_eof_q    <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            col_sum_p0_q <= col_sum_p0_d;
            col_p0_q     <= col_p0_d;
            row_p0_q     <= row_p0_d;
            acc_p0_q     <= acc_p0_d;
            vld_p0_q     <= vld_p0_d;
            eof_p0_q     <= eof_p0_d;
            hist_q       <= hist_d;
            win_sum_p1_q <= win_sum_p1_d;
            col_p1_q     <= col_p1_d;
            row_p1_q     <= row_p1_d;
            vld_p1_q     <= vld_p1_d;
            eof_p1_q     <= eof_p1_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_eof_q    <= out_eof_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_eof   = out_eof_q;

endmodule
